// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD coprocessor between N requesters.
// Round-robin grant with a hold-while-presented lock on the issue side.
// An in-order tag FIFO steers each returning result to the requester that
// issued it. Both directions are zero-latency combinational paths.
//
// Handshake rule (every val/rdy pair in this block): a transfer happens on the
// rising edge where val and rdy are both high. A producer keeps val and its
// data stable until that transfer. The coprocessor returns results in the
// same order it accepted operands.
module gcd_arbiter #(
  parameter int W     = 32,
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             req_val,
  output logic [N-1:0]             req_rdy,
  input  logic [N*W-1:0]           req_bits_A,
  input  logic [N*W-1:0]           req_bits_B,
  output logic [N-1:0]             resp_val,
  input  logic [N-1:0]             resp_rdy,
  output logic [W-1:0]             resp_bits,
  output logic                     gcd_operands_val,
  input  logic                     gcd_operands_rdy,
  output logic [W-1:0]             gcd_operands_bits_A,
  output logic [W-1:0]             gcd_operands_bits_B,
  input  logic                     gcd_result_val,
  output logic                     gcd_result_rdy,
  input  logic [W-1:0]             gcd_result_bits,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_orphan
);

  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW:0] N_WIDE = (TW+1)'(N);

  // Arbitration state
  logic [TW-1:0] ptr_q, ptr_d;
  logic          locked_q, locked_d;
  logic [TW-1:0] lidx_q, lidx_d;

  // Tag FIFO state
  logic [TW-1:0] tags_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_orphan_q, err_orphan_d;

  logic          any_grant;
  logic [TW-1:0] grant;
  logic [TW:0]   scan_idx;
  logic          full, empty;
  logic [TW-1:0] head_tag;
  logic          issue_fire, return_fire;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_tag = tags_q[head_q];

  // Grant: the locked index while locked, else first valid from ptr upward
  always_comb begin
    any_grant = 1'b0;
    grant     = '0;
    scan_idx  = '0;
    if (locked_q) begin
      any_grant = 1'b1;
      grant     = lidx_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_idx = {1'b0, ptr_q} + (TW+1)'(k);
        if (scan_idx >= N_WIDE) scan_idx = scan_idx - N_WIDE;
        if (!any_grant && req_val[scan_idx[TW-1:0]]) begin
          any_grant = 1'b1;
          grant     = scan_idx[TW-1:0];
        end
      end
    end
  end

  // Issue side; all handshake outputs are forced low while in reset
  assign gcd_operands_val    = !reset && any_grant && !full;
  assign gcd_operands_bits_A = any_grant ? req_bits_A[grant*W +: W] : '0;
  assign gcd_operands_bits_B = any_grant ? req_bits_B[grant*W +: W] : '0;
  assign issue_fire          = gcd_operands_val && gcd_operands_rdy;

  // Only the granted requester may see its accept
  always_comb begin
    req_rdy = '0;
    if (!reset && any_grant && !full && gcd_operands_rdy) req_rdy[grant] = 1'b1;
  end

  // Return side: the head tag picks which requester sees the result
  always_comb begin
    resp_val = '0;
    if (!reset && !empty) resp_val[head_tag] = gcd_result_val;
  end

  assign gcd_result_rdy = !reset && !empty && resp_rdy[head_tag];
  assign resp_bits      = gcd_result_bits;
  assign return_fire    = gcd_result_val && gcd_result_rdy;

  assign outstanding = count_q;
  assign err_orphan  = err_orphan_q;

  // Next-state: pointer advance, lock, FIFO pointers/count, orphan flag
  always_comb begin
    ptr_d        = ptr_q;
    locked_d     = locked_q;
    lidx_d       = lidx_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q;
    if (issue_fire) begin
      ptr_d    = (grant == TW'(N-1)) ? '0 : grant + 1'b1;
      locked_d = 1'b0;
      tail_d   = tail_q + 1'b1;
    end else if (gcd_operands_val) begin
      // Presented but not taken: freeze the grant until it fires
      locked_d = 1'b1;
      lidx_d   = grant;
    end
    if (return_fire) head_d = head_q + 1'b1;
    case ({issue_fire, return_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (!reset && gcd_result_val && empty) err_orphan_d = 1'b1;
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      locked_q     <= 1'b0;
      lidx_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      locked_q     <= locked_d;
      lidx_q       <= lidx_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag storage; contents are don't-care outside head..tail
  always_ff @(posedge clk) begin
    if (issue_fire) tags_q[tail_q] <= grant;
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: a behavioural coprocessor model, a per-requester
// operand source, and a scoreboard of expected results per requester plus
// the global return order.
module tb_gcd_arbiter;

  localparam int W     = 32;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_val = '0;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req_bits_A = '0;
  logic [N*W-1:0] req_bits_B = '0;
  logic [N-1:0]   resp_val;
  logic [N-1:0]   resp_rdy = '0;
  logic [W-1:0]   resp_bits;
  logic           gcd_operands_val;
  logic           gcd_operands_rdy = 1'b0;
  logic [W-1:0]   gcd_operands_bits_A;
  logic [W-1:0]   gcd_operands_bits_B;
  logic           gcd_result_val = 1'b0;
  logic           gcd_result_rdy;
  logic [W-1:0]   gcd_result_bits = '0;
  logic [CW-1:0]  outstanding;
  logic           err_orphan;

  gcd_arbiter #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_bits_A(req_bits_A), .req_bits_B(req_bits_B),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_bits(resp_bits),
    .gcd_operands_val(gcd_operands_val), .gcd_operands_rdy(gcd_operands_rdy),
    .gcd_operands_bits_A(gcd_operands_bits_A), .gcd_operands_bits_B(gcd_operands_bits_B),
    .gcd_result_val(gcd_result_val), .gcd_result_rdy(gcd_result_rdy),
    .gcd_result_bits(gcd_result_bits),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  // ---------------- bench state ----------------
  typedef struct {
    logic [W-1:0] res;
    int           rdy_cyc;
  } cop_t;

  cop_t           pipe[$];          // coprocessor in-flight results, in order
  logic [2*W-1:0] src_q[N][$];      // operand pairs each requester will send
  logic [W-1:0]   exp_q[N][$];      // expected results per requester
  int             exp_tag_q[$];     // expected global return order
  int             issue_log[$];
  int             resp_cnt[N];
  logic [N-1:0]   fired = '0;
  logic [N-1:0]   resp_block = '0;
  int op_prob = 100, resp_prob = 100, lat_min = 1, lat_max = 3;
  int cop_allow = -1;
  logic spurious = 1'b0;
  int cyc = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [2*W-1:0] rand_pair();
    logic [W-1:0] f, a, b;
    f = W'($urandom_range(1, 20000));
    a = f * W'($urandom_range(1, 60));
    b = f * W'($urandom_range(1, 60));
    return {a, b};
  endfunction

  // ---------------- drivers (posedge + 1) ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        fired[i] = 1'b0;
      end
      if (src_q[i].size() > 0) begin
        req_val[i] = 1'b1;
        req_bits_A[i*W +: W] = src_q[i][0][2*W-1:W];
        req_bits_B[i*W +: W] = src_q[i][0][W-1:0];
      end else begin
        req_val[i] = 1'b0;
        req_bits_A[i*W +: W] = '0;
        req_bits_B[i*W +: W] = '0;
      end
      resp_rdy[i] = resp_block[i] ? 1'b0 : ($urandom_range(0, 99) < op_dummy(resp_prob));
    end
    gcd_operands_rdy = ($urandom_range(0, 99) < op_dummy(op_prob));
    if (pipe.size() > 0 && pipe[0].rdy_cyc <= cyc && cop_allow != 0) begin
      gcd_result_val  = 1'b1;
      gcd_result_bits = pipe[0].res;
    end else if (spurious && pipe.size() == 0) begin
      gcd_result_val  = 1'b1;
      gcd_result_bits = $urandom;
    end else begin
      gcd_result_val  = 1'b0;
      gcd_result_bits = '0;
    end
  end

  function automatic int op_dummy(input int p);
    return p;
  endfunction

  // ---------------- monitor / scoreboard (negedge) ----------------
  always @(negedge clk) begin
    cop_t e;
    if (!reset) begin
      chk("outstanding", 64'(outstanding), 64'(exp_tag_q.size()));
      if (|req_rdy) chk("req_rdy_onehot", 64'($countones(req_rdy)), 1);
      for (int i = 0; i < N; i++) begin
        if (resp_val[i] && resp_rdy[i]) begin
          resp_cnt[i]++;
          chk("resp_pending", 64'(exp_tag_q.size() > 0 && exp_q[i].size() > 0), 1);
          if (exp_tag_q.size() > 0 && exp_q[i].size() > 0) begin
            chk("resp_order", 64'(i), 64'(exp_tag_q.pop_front()));
            chk("resp_data", 64'(resp_bits), 64'(exp_q[i].pop_front()));
          end
        end
      end
      if (gcd_result_val && gcd_result_rdy && pipe.size() > 0) begin
        void'(pipe.pop_front());
        if (cop_allow > 0) cop_allow--;
      end
      for (int i = 0; i < N; i++) begin
        if (req_val[i] && req_rdy[i] && src_q[i].size() > 0) begin
          exp_q[i].push_back(gcd_ref(src_q[i][0][2*W-1:W], src_q[i][0][W-1:0]));
          exp_tag_q.push_back(i);
          issue_log.push_back(i);
          fired[i] = 1'b1;
        end
      end
      if (gcd_operands_val && gcd_operands_rdy) begin
        e.res     = gcd_ref(gcd_operands_bits_A, gcd_operands_bits_B);
        e.rdy_cyc = cyc + int'($urandom_range(lat_min, lat_max));
        pipe.push_back(e);
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      resp_cnt[i] = 0;
    end
    fired = '0;
    exp_tag_q.delete();
    issue_log.delete();
    pipe.delete();
    op_prob = 100; resp_prob = 100; lat_min = 1; lat_max = 3;
    cop_allow = -1; spurious = 1'b0; resp_block = '0;
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 0);
    chk("rst_resp_val", 64'(resp_val), 0);
    chk("rst_op_val", 64'(gcd_operands_val), 0);
    chk("rst_res_rdy", 64'(gcd_result_rdy), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_err_orphan", 64'(err_orphan), 0);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_out(input int v, input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(outstanding) != v && n < limit);
    chk(name, 64'(outstanding), 64'(v));
  endtask

  task automatic drain();
    int n, pend;
    op_prob = 100; resp_prob = 100; resp_block = '0; cop_allow = -1; spurious = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pend = exp_tag_q.size() + pipe.size();
      for (int i = 0; i < N; i++) pend += src_q[i].size();
    end while (pend != 0 && n < 3000);
    chk("drain_pending", 64'(pend), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int rr_exp[3];
    logic [W-1:0] g3;
    rr_exp = '{0, 2, 3};

    do_reset();

    // Single requester: (27,15) -> 3 on port 1
    lat_min = 2; lat_max = 2;
    src_q[1].push_back({32'd27, 32'd15});
    wait_out(1, 20, "single_out1");
    wait_out(0, 20, "single_out0");
    chk("single_resp_cnt", 64'(resp_cnt[1]), 1);

    // Round-robin across 0, 2, 3
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back(rand_pair());
      src_q[2].push_back(rand_pair());
      src_q[3].push_back(rand_pair());
    end
    n = 0;
    while (issue_log.size() < 9 && n < 200) begin @(negedge clk); n++; end
    chk("rr_issue_cnt", 64'(issue_log.size() >= 9), 1);
    if (issue_log.size() >= 9)
      for (int k = 0; k < 9; k++) chk("rr_order", 64'(issue_log[k]), 64'(rr_exp[k % 3]));
    drain();

    // Lock: req 2 presented with coprocessor stalled, req 0 arrives later
    do_reset();
    op_prob = 0;
    src_q[2].push_back({32'd84, 32'd36});
    @(posedge clk); @(posedge clk); #2;
    src_q[0].push_back({32'd35, 32'd21});
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_grant_A", 64'(gcd_operands_bits_A), 84);
      chk("lock_no_rdy", 64'(req_rdy), 0);
    end
    op_prob = 100;
    n = 0;
    while (issue_log.size() < 2 && n < 20) begin @(negedge clk); n++; end
    chk("lock_issue_cnt", 64'(issue_log.size() >= 2), 1);
    if (issue_log.size() >= 2) begin
      chk("lock_first", 64'(issue_log[0]), 2);
      chk("lock_second", 64'(issue_log[1]), 0);
    end
    drain();

    // Full: four issued, no results; one return frees a slot next cycle
    do_reset();
    cop_allow = 0; lat_min = 0; lat_max = 0;
    for (int k = 0; k < 5; k++) src_q[1].push_back(rand_pair());
    wait_out(4, 30, "full_out4");
    @(negedge clk);
    chk("full_blocked", 64'(gcd_operands_val), 0);
    chk("full_out_hold", 64'(outstanding), 4);
    cop_allow = 1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(gcd_result_val && gcd_result_rdy) && n < 20);
    chk("full_pop_seen", 64'(gcd_result_val && gcd_result_rdy), 1);
    chk("full_no_bypass", 64'(gcd_operands_val), 0);
    @(negedge clk);
    chk("full_resume", 64'(gcd_operands_val), 1);
    chk("full_out3", 64'(outstanding), 3);
    drain();
    chk("full_all_back", 64'(resp_cnt[1]), 5);

    // Response backpressure on head tag 3
    do_reset();
    lat_min = 0; lat_max = 0;
    resp_block = 4'b1000;
    g3 = gcd_ref(32'd91, 32'd65);
    src_q[3].push_back({32'd91, 32'd65});
    n = 0;
    while (issue_log.size() < 1 && n < 20) begin @(negedge clk); n++; end
    src_q[0].push_back(rand_pair());
    src_q[1].push_back(rand_pair());
    n = 0;
    do begin @(negedge clk); n++; end while (!gcd_result_val && n < 20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_res_rdy", 64'(gcd_result_rdy), 0);
      chk("bp_resp_val", 64'(resp_val), 64'(4'b1000));
      chk("bp_resp_bits", 64'(resp_bits), 64'(g3));
    end
    chk("bp_no_overtake", 64'(resp_cnt[0] + resp_cnt[1]), 0);
    drain();
    chk("bp_cnt3", 64'(resp_cnt[3]), 1);
    chk("bp_cnt01", 64'(resp_cnt[0] + resp_cnt[1]), 2);

    // Reset with two requests outstanding
    do_reset();
    cop_allow = 0;
    src_q[0].push_back(rand_pair());
    src_q[2].push_back(rand_pair());
    wait_out(2, 20, "rst2_out2");
    do_reset();
    repeat (10) @(negedge clk);
    chk("rst2_orphan", 64'(err_orphan), 0);
    chk("rst2_out", 64'(outstanding), 0);

    // Orphan result with empty FIFO
    spurious = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("orphan_no_ack", 64'(gcd_result_rdy), 0);
    chk("orphan_resp_val", 64'(resp_val), 0);
    spurious = 1'b0;
    @(negedge clk);
    chk("orphan_set", 64'(err_orphan), 1);
    repeat (5) @(negedge clk);
    chk("orphan_sticky", 64'(err_orphan), 1);
    do_reset();

    // Randomized traffic
    lat_min = 0; lat_max = 5;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        op_prob   = int'($urandom_range(30, 100));
        resp_prob = int'($urandom_range(30, 100));
      end
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 3 && $urandom_range(0, 99) < 40) src_q[i].push_back(rand_pair());
      @(posedge clk); #2;
    end
    drain();
    for (int i = 0; i < N; i++) chk("final_exp_empty", 64'(exp_q[i].size()), 0);
    chk("final_orphan", 64'(err_orphan), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
